// File: rtl/banked_scratchpad_pkg.sv
// Shared helpers for the banked scratchpad memory.
//   bank_sel_width : number of address bits used to pick a bank (0 for a single bank)
//   row_width      : number of address bits left over for the row inside a bank
//   port_req_t     : one port's request fields (we, addr, wdata, strb) for the default geometry
package banked_scratchpad_pkg;

  function automatic int unsigned bank_sel_width(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  function automatic int unsigned row_width(input int unsigned addr_width,
                                            input int unsigned num_banks);
    return addr_width - bank_sel_width(num_banks);
  endfunction

  localparam int unsigned DefNumBanks  = 4;
  localparam int unsigned DefBankDepth = 256;
  localparam int unsigned DefDataWidth = 128;
  localparam int unsigned DefAddrWidth = $clog2(DefNumBanks * DefBankDepth);
  localparam int unsigned DefStrbWidth = DefDataWidth / 8;

  typedef struct packed {
    logic                    we;
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] wdata;
    logic [DefStrbWidth-1:0] strb;
  } port_req_t;

endpackage

// File: rtl/banked_scratchpad_memory_rr_arbiter.sv
// Round-robin arbiter, one instance per bank.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector, one bit per port
//   gnt_o         : one-hot grant (all zero when nothing requests)
// The first requester at or after the pointer wins; the pointer then moves to
// winner+1 (mod NumReq) and stays put when nothing is granted.
module rr_arbiter #(
  parameter int unsigned NumReq = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;
  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = PtrW'((32'(ptr_q) + i) % NumReq);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = (32'(idx) == NumReq - 1) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/banked_scratchpad_memory.sv
// Multi-port, multi-bank scratchpad with low-order address interleaving.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i, we_i   : per-port request valid and write enable
//   addr_i        : per-port word address (low bits select the bank)
//   wdata_i/strb_i: per-port write data and byte enables
//   gnt_o         : per-port combinational grant (forced low in reset)
//   rvalid_o      : per-port read data valid, one cycle after a read grant
//   rdata_o       : per-port registered read data, held while rvalid_o is low
module banked_scratchpad_memory
  import banked_scratchpad_pkg::*;
#(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned BankDepth = 256,
  parameter int unsigned AddrWidth = $clog2(NumBanks * BankDepth),
  parameter int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic        [NumPorts-1:0]                req_i,
  input  logic        [NumPorts-1:0]                we_i,
  input  logic        [NumPorts-1:0][AddrWidth-1:0] addr_i,
  input  logic signed [NumPorts-1:0][DataWidth-1:0] wdata_i,
  input  logic        [NumPorts-1:0][StrbWidth-1:0] strb_i,
  output logic        [NumPorts-1:0]                gnt_o,
  output logic        [NumPorts-1:0]                rvalid_o,
  output logic signed [NumPorts-1:0][DataWidth-1:0] rdata_o
);

  localparam int unsigned BankSelW = bank_sel_width(NumBanks);
  localparam int unsigned RowW     = row_width(AddrWidth, NumBanks);
  localparam int unsigned BankIdxW = (BankSelW > 0) ? BankSelW : 1;

  logic [BankIdxW-1:0]  bank_of    [NumPorts];
  logic [RowW-1:0]      row_of     [NumPorts];
  logic [NumPorts-1:0]  bank_gnt   [NumBanks];
  logic [DataWidth-1:0] bank_rdata [NumBanks];
  logic [NumPorts-1:0]  gnt_raw;
  logic [NumPorts-1:0]  rvalid_q;
  logic [NumPorts-1:0][DataWidth-1:0] rdata_q;

  for (genvar p = 0; p < NumPorts; p++) begin : g_decode
    if (BankSelW > 0) begin : g_banked
      assign bank_of[p] = addr_i[p][BankSelW-1:0];
      assign row_of[p]  = addr_i[p][AddrWidth-1:BankSelW];
    end else begin : g_single
      assign bank_of[p] = '0;
      assign row_of[p]  = addr_i[p];
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [NumPorts-1:0]  breq;
    logic [NumPorts-1:0]  bgnt;
    logic                 w_en;
    logic [RowW-1:0]      a_row;
    logic [DataWidth-1:0] w_data;
    logic [StrbWidth-1:0] w_strb;
    logic [DataWidth-1:0] mem_q [BankDepth];

    always_comb begin
      breq = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
        breq[p] = req_i[p] && (bank_of[p] == BankIdxW'(b));
      end
    end

    rr_arbiter #(
      .NumReq(NumPorts)
    ) u_arb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .req_i (breq),
      .gnt_o (bgnt)
    );

    assign bank_gnt[b] = bgnt;

    // Winner's fields steer the single bank port; reset blocks any write.
    always_comb begin
      w_en   = 1'b0;
      a_row  = '0;
      w_data = '0;
      w_strb = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (bgnt[p]) begin
          w_en   = rst_ni && we_i[p];
          a_row  = row_of[p];
          w_data = wdata_i[p];
          w_strb = strb_i[p];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (w_en && (32'(a_row) < BankDepth)) begin
        for (int unsigned k = 0; k < StrbWidth; k++) begin
          if (w_strb[k]) begin
            mem_q[a_row][8*k +: 8] <= w_data[8*k +: 8];
          end
        end
      end
    end

    assign bank_rdata[b] = mem_q[a_row];
  end

  always_comb begin
    gnt_raw = '0;
    for (int unsigned b = 0; b < NumBanks; b++) begin
      gnt_raw = gnt_raw | bank_gnt[b];
    end
  end

  assign gnt_o = rst_ni ? gnt_raw : '0;

  // Bank-to-port return mux is captured in the port's own register so the
  // data stays stable while the bank serves other ports.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        rvalid_q[p] <= gnt_o[p] && !we_i[p];
        if (gnt_o[p] && !we_i[p]) begin
          rdata_q[p] <= bank_rdata[bank_of[p]];
        end
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: doc/banked_scratchpad_memory.md
# banked_scratchpad_memory

Multi-port, multi-bank on-chip scratchpad memory. It replaces the single-port combinational-read memory wherever more than one client (for example, the activation loader and the result writer of the PE array) must reach the same buffer. Addresses are low-order interleaved across banks. Same-bank conflicts are resolved per bank by a round-robin arbiter with a req/gnt handshake. Reads have a registered one-cycle latency, and writes support byte strobes.

## Interface
Parameters:
- NumPorts, 2, number of requesting ports (≥1)
- NumBanks, 4, number of banks (power of two, ≥1)
- DataWidth, 128, word width in bits (multiple of 8)
- BankDepth, 256, words per bank
- AddrWidth, $clog2(NumBanks*BankDepth), word address width
- StrbWidth, DataWidth/8, byte-strobe width

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  [NumPorts]  request valid per port
- we_i  in  [NumPorts]  1 = write, 0 = read
- addr_i  in  [NumPorts][AddrWidth]  word address
- wdata_i  in  [NumPorts][DataWidth]  write data (signed)
- strb_i  in  [NumPorts][StrbWidth]  byte enables for writes
- gnt_o  out  [NumPorts]  request accepted this cycle
- rvalid_o  out  [NumPorts]  read data valid
- rdata_o  out  [NumPorts][DataWidth]  read data (signed)

## Operation
- Bank select is addr_i[$clog2(NumBanks)-1:0]. Row is the remaining upper bits. When NumBanks=1, the bank bits are absent and row = addr_i.
- Each bank serves at most one access per cycle. Per bank, the winner is chosen among ports with req_i high targeting that bank.
- Arbitration is round-robin per bank. Pointer reset value is 0. The port at or after the pointer wins. After a grant, the pointer moves to winner+1 mod NumPorts. With no grant, the pointer is unchanged.
- gnt_o is combinational from req_i/addr_i in the same cycle. A port never gets gnt_o without req_i.
- Handshake: a transfer occurs when req_i && gnt_o. An ungranted port keeps req_i high with we/addr/wdata/strb stable until granted. The block does not check this.
- Granted write: bytes with strb_i[b]=1 are updated at the clock edge, other bytes are unchanged. strb_i=0 is a legal no-op write, still granted. Writes never raise rvalid_o.
- Granted read: the row is read at the edge into the port's rdata register. rvalid_o is high for exactly the next cycle.
- rdata_o holds its last value while rvalid_o is low.
- Two ports accessing different banks are both granted in the same cycle.
- Write to an address in cycle N, then read of it in cycle N+1: the read returns the new data.
- Same-cycle read and write to one address cannot happen, because one access per bank per cycle.
- Out-of-range rows (BankDepth not a power of two) are behaviourally undefined: writes are dropped and reads return X. The assertion bench flags them.

## Timing
- Reset values: gnt_o=0 while rst_ni is low (forced), rvalid_o=0, rdata_o=0, all RR pointers=0. Memory contents are not reset.
- Read latency: 1 cycle from the grant edge to rvalid_o. Throughput is 1 access per bank per cycle.
- Reset asserted mid-operation: any rvalid pending from the last grant is dropped, and there are no partial writes after the reset edge. After release, arbitration restarts from port 0.
- Back-to-back reads from one port on consecutive cycles give rvalid_o high continuously with new rdata_o each cycle.
- With NumPorts=1, gnt_o = req_i in every cycle (out of reset).

## Structure
- Package banked_scratchpad_pkg holds:
  - the BankSelWidth and RowWidth localparam helper functions;
  - a typedef for the per-port request struct (we, addr, wdata, strb).
- Sub-module rr_arbiter (parameter NumReq) is instantiated once per bank. Its interface: req vector in, one-hot gnt out, pointer register inside, update on grant.
- Bank storage uses a generate loop of byte-strobed arrays. The read registers are per port, and a bank→port return mux is registered alongside rvalid.

## Test plan
- Reset: hold rst_ni low with req_i=2'b11 → gnt_o=0, rvalid_o=0, rdata_o=0. Release: first grant to port 0 on a bank conflict.
- Port 0 writes 0x1234…, strb all-ones, to addr 5; next cycle reads addr 5 → rvalid_o[0]=1 one cycle later, rdata_o[0]=0x1234….
- Byte strobe: write all-0xFF to addr 8, then write 0x00 with strb=16'h0001 → readback has byte 0 = 0x00 and bytes 1–15 = 0xFF.
- Conflict: both ports read addr 0 and addr 4 (bank 0) for 4 cycles → grants alternate 0,1,0,1 and each rvalid pairs with its own data.
- Parallel: port 0 reads addr 1 (bank 1) and port 1 reads addr 2 (bank 2) in the same cycle → both gnt_o=1, both rvalid_o=1 next cycle.
- Reset mid-read: grant a read, then assert rst_ni before the next edge → rvalid_o stays 0 and rdata_o=0.
